// File: rtl/seq_updown_fsm.sv
// seq_updown_fsm: up/down sequencer stepping through a runtime-writable table of state codes
module seq_updown_fsm #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             wrap_en,
   input  logic             load,
   input  logic [IDX_W-1:0] load_idx,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_code,
   output logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] code,
   output logic             tc,
   output logic             sat
);
   typedef enum logic {RUN, HOLD} state_t;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);
   state_t state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic tc_q, tc_d, sat_q;
   logic [WIDTH-1:0] seq_q [DEPTH];
   logic at_top, at_bot, wr_ok;
   assign at_top = idx_q == LAST;
   assign at_bot = idx_q == '0;
   assign wr_ok = {1'b0, wr_idx} < DEPTH_X;
   assign idx = idx_q;
   assign code = seq_q[idx_q];
   assign tc = tc_q;
   assign sat = sat_q;
   // In HOLD only a step away from the held end (or a load) moves the index
   always_comb begin
      idx_d = idx_q;
      state_d = state_q;
      tc_d = 1'b0;
      if (load) begin
         idx_d = ({1'b0, load_idx} >= DEPTH_X) ? LAST : load_idx;
         state_d = RUN;
      end else if (en && (state_q == RUN || (up ? at_bot : at_top))) begin
         if (up ? at_top : at_bot) begin
            tc_d = 1'b1;
            state_d = wrap_en ? RUN : HOLD;
            idx_d = wrap_en ? (up ? '0 : LAST) : idx_q;
         end else begin
            idx_d = up ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
            state_d = RUN;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         idx_q <= '0;
         tc_q <= 1'b0;
         sat_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         tc_q <= tc_d;
         sat_q <= state_d == HOLD;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) seq_q[i] <= WIDTH'(i);
      end else if (wr_en && wr_ok) begin
         seq_q[wr_idx] <= wr_code;
      end
   end
endmodule
